// File: rtl/syntzulu_ser_pkg.sv
// Shared types, constants and sizing helpers for the FIFO byte serializer.
package syntzulu_ser_pkg;

    // Serializer FSM encoding
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Frame header byte sent ahead of each word when headers are enabled
    localparam logic [7:0] SER_HEADER = 8'hA5;

    // Number of bytes needed to carry a word of the given width
    function automatic int unsigned nbytes(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

    // Ceiling log2; clogb2(DEPTH+1) is the width needed to hold 0..DEPTH
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 32'd0) ? value - 32'd1 : 32'd0;
        r = 32'd0;
        while (v > 32'd0) begin
            r = r + 32'd1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_occ_counter.sv
// Occupancy tracker for a flagless FIFO: counts writes minus pops and
// raises a sticky overflow when a write lands on a full FIFO.
module fifo_occ_counter
    import syntzulu_ser_pkg::*;
#(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned CW    = clogb2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wren,
    input  logic          rden,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Next occupancy: a write on a full FIFO overwrote unread data
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        unique case ({wren, rden})
            2'b10: begin
                if (count_q == DEPTH_C) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Occupancy and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/fifo_serializer.sv
// Pops words from a flagless event FIFO and streams them LSB-byte-first
// over a valid/ready byte interface.
// Optional build macro: SER_FRAME_HEADER_EN prepends header byte 0xA5
// to every word.
module fifo_serializer
    import syntzulu_ser_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 25,
    parameter  int unsigned DEPTH      = 256,
    localparam int unsigned CW         = clogb2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_wren,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    output logic                  fifo_rden,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned NBYTES = nbytes(DATA_WIDTH);
    localparam int unsigned DW     = 8 * NBYTES;
`ifdef SER_FRAME_HEADER_EN
    localparam int unsigned HDR    = 1;
`else
    localparam int unsigned HDR    = 0;
`endif
    localparam int unsigned NOUT   = NBYTES + HDR;
    localparam int unsigned SW     = 8 * NOUT;
    localparam int unsigned IW     = (clogb2(NOUT) > 0) ? clogb2(NOUT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NOUT - 1);

    ser_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          tx_valid_q, tx_valid_d;
    logic [DW-1:0] word_ext;
    logic [SW-1:0] load_word;

    // Occupancy is inferred by snooping the FIFO write strobe and our pops
    fifo_occ_counter #(
        .DEPTH (DEPTH)
    ) u_occ (
        .clk      (clk),
        .rst      (rst),
        .wren     (fifo_wren),
        .rden     (fifo_rden),
        .count    (count),
        .overflow (overflow)
    );

    // Word as it enters the shift register; byte 0 is the first one sent
    always_comb begin
        word_ext = DW'(fifo_do);
`ifdef SER_FRAME_HEADER_EN
        load_word = {word_ext, SER_HEADER};
`else
        load_word = word_ext;
`endif
    end

    // Pop exactly when the FSM is about to load a word
    assign fifo_rden = (state_q == IDLE) && (count != '0);

    // Next-state and datapath: load on pop, shift one byte per accept
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            IDLE: begin
                if (fifo_rden) begin
                    shift_d    = load_word;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 8;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and datapath registers; reset discards any partial word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data  = shift_q[7:0];
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != IDLE) || (count != '0);

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer with a flagless FIFO stub in front.
// Honours SER_FRAME_HEADER_EN for the expected byte stream.
module tb_fifo_serializer;
    import syntzulu_ser_pkg::*;

    localparam int DW    = 25;
    localparam int DEPTH = 256;
`ifdef SER_FRAME_HEADER_EN
    localparam int NOUT  = 5;
    localparam int HOFF  = 1;
`else
    localparam int NOUT  = 4;
    localparam int HOFF  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_wren;
    logic [DW-1:0] din;
    logic [DW-1:0] fifo_do;
    logic          fifo_rden;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [8:0]    count;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    fifo_serializer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_wren (fifo_wren),
        .fifo_do   (fifo_do),
        .fifo_rden (fifo_rden),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .count     (count),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Flagless FIFO stub: circular buffer, read data at the read pointer
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [7:0]    wp, rp;
    assign fifo_do = mem[rp];
    always @(posedge clk) begin
        if (rst) begin
            wp <= 8'd0;
            rp <= 8'd0;
        end else begin
            if (fifo_wren) begin
                mem[wp] <= din;
                wp      <= wp + 8'd1;
            end
            if (fifo_rden) rp <= rp + 8'd1;
        end
    end

    int vectors = 0;
    int fails   = 0;

    logic [7:0] got[$];
    int         got_t[$];
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         rden_cnt, max_count, stab_err;
    logic       prev_hold;
    logic [7:0] prev_data;

    typedef struct {
        logic          wren;
        logic [DW-1:0] d;
        logic          ready;
        logic          rden;
        logic          valid;
        logic [7:0]    data;
        logic [8:0]    cnt;
        logic          bsy;
    } vec_t;

    vec_t tv [0:7];
    int   nv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Sample outputs mid-cycle, record the stream, then move to the next negedge
    task automatic tick();
        #1;
        if (prev_hold && (!tx_valid || tx_data != prev_data)) stab_err++;
        prev_hold = tx_valid && !tx_ready && !rst;
        prev_data = tx_data;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                got_t.push_back(cyc);
            end
            if (fifo_rden) rden_cnt++;
            if (int'(count) > max_count) max_count = int'(count);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_mon();
        got.delete();
        got_t.delete();
        exp_q.delete();
        rden_cnt  = 0;
        max_count = 0;
        stab_err  = 0;
        prev_hold = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fifo_wren = 1'b0;
        tx_ready  = 1'b0;
        din       = '0;
        tick();
        tick();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        fifo_wren = 1'b1;
        din       = w;
        tick();
        fifo_wren = 1'b0;
    endtask

    function automatic logic [7:0] exp_byte(input logic [DW-1:0] w, input int k);
        logic [31:0] x;
        int j;
        x = {7'b0, w};
        if (HOFF == 1 && k == 0) return SER_HEADER;
        j = k - HOFF;
        return x[j*8 +: 8];
    endfunction

    task automatic push_exp(input logic [DW-1:0] w);
        for (int k = 0; k < NOUT; k++) exp_q.push_back(exp_byte(w, k));
    endtask

    task automatic compare_stream(input string name);
        int n;
        check($sformatf("%s_len", name), got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("%s_idle", name), 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hold;

        // Scenario 1 table: one word, ready held high (cycle-accurate)
        tv[0] = '{1'b1, 25'h1ABCDEF, 1'b1, 1'b0, 1'b0, 8'h00, 9'd0, 1'b0};
        tv[1] = '{1'b0, 25'h0,       1'b1, 1'b1, 1'b0, 8'h00, 9'd1, 1'b1};
`ifdef SER_FRAME_HEADER_EN
        tv[2] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'hA5, 9'd0, 1'b1};
        tv[3] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'hEF, 9'd0, 1'b1};
        tv[4] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'hCD, 9'd0, 1'b1};
        tv[5] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'hAB, 9'd0, 1'b1};
        tv[6] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'h01, 9'd0, 1'b1};
        tv[7] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b0, 8'h00, 9'd0, 1'b0};
        nv = 8;
`else
        tv[2] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'hEF, 9'd0, 1'b1};
        tv[3] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'hCD, 9'd0, 1'b1};
        tv[4] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'hAB, 9'd0, 1'b1};
        tv[5] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b1, 8'h01, 9'd0, 1'b1};
        tv[6] = '{1'b0, 25'h0,       1'b1, 1'b0, 1'b0, 8'h00, 9'd0, 1'b0};
        nv = 7;
`endif

        // Reset state
        do_reset();
        #1;
        check("rst_count",    32'(count),     32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_valid",    32'(tx_valid),  32'd0);
        check("rst_data",     32'(tx_data),   32'd0);
        check("rst_rden",     32'(fifo_rden), 32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        @(negedge clk);

        // Scenario 1: table-driven single word
        for (int i = 0; i < nv; i++) begin
            fifo_wren = tv[i].wren;
            din       = tv[i].d;
            tx_ready  = tv[i].ready;
            #1;
            check($sformatf("s1_c%0d_rden", i),  32'(fifo_rden), 32'(tv[i].rden));
            check($sformatf("s1_c%0d_valid", i), 32'(tx_valid),  32'(tv[i].valid));
            check($sformatf("s1_c%0d_count", i), 32'(count),     32'(tv[i].cnt));
            check($sformatf("s1_c%0d_busy", i),  32'(busy),      32'(tv[i].bsy));
            if (tv[i].valid)
                check($sformatf("s1_c%0d_data", i), 32'(tx_data), 32'(tv[i].data));
            @(negedge clk);
        end
        fifo_wren = 1'b0;

        // Scenario 2: three back-to-back words, ready high
        do_reset();
        tx_ready = 1'b1;
        push_exp(25'h0123456);
        push_exp(25'h1FEDCBA);
        push_exp(25'h0A5A5A5);
        write_word(25'h0123456);
        write_word(25'h1FEDCBA);
        write_word(25'h0A5A5A5);
        wait_idle("s2", 100);
        compare_stream("s2");
        check("s2_rden_pulses", 32'(rden_cnt), 32'd3);
        check("s2_count_peak", 32'(max_count), 32'd2);
        for (int i = 1; i < got_t.size(); i++)
            check($sformatf("s2_gap%0d", i), 32'(got_t[i] - got_t[i-1]),
                  (i % NOUT == 0) ? 32'd2 : 32'd1);

        // Scenario 3: ready low for 5 cycles mid-word
        do_reset();
        tx_ready = 1'b1;
        push_exp(25'h0C0FFEE);
        write_word(25'h0C0FFEE);
        hold = 0;
        n = 0;
        while (busy && n < 100) begin
            tx_ready = !(got.size() == 2 && hold < 5);
            if (!tx_ready) hold++;
            tick();
            n++;
        end
        check("s3_idle", 32'(busy), 32'd0);
        check("s3_hold_cycles", 32'(hold), 32'd5);
        check("s3_stable", 32'(stab_err), 32'd0);
        check("s3_rden_pulses", 32'(rden_cnt), 32'd1);
        compare_stream("s3");

        // Scenario 4: simultaneous write and pop at count 2
        do_reset();
        tx_ready = 1'b0;
        write_word(25'h0000011);
        write_word(25'h0000022);
        write_word(25'h0000033);
        #1;
        check("s4_pre_count", 32'(count), 32'd2);
        @(negedge clk);
        tx_ready = 1'b1;
        repeat (NOUT) tick();
        fifo_wren = 1'b1;
        din       = 25'h0000044;
        #1;
        check("s4_rden", 32'(fifo_rden), 32'd1);
        check("s4_count_before", 32'(count), 32'd2);
        @(negedge clk);
        fifo_wren = 1'b0;
        #1;
        check("s4_count_after", 32'(count), 32'd2);
        @(negedge clk);
        wait_idle("s4", 200);

        // Scenario 5: fill to DEPTH, overflow, drain, reset
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 257; i++) write_word(25'(i));
        #1;
        check("s5_count_full", 32'(count), 32'd256);
        check("s5_ovf_not_yet", 32'(overflow), 32'd0);
        @(negedge clk);
        write_word(25'h1555555);
        #1;
        check("s5_count_hold", 32'(count), 32'd256);
        check("s5_ovf_set", 32'(overflow), 32'd1);
        @(negedge clk);
        tx_ready = 1'b1;
        wait_idle("s5", 3000);
        #1;
        check("s5_count_drained", 32'(count), 32'd0);
        check("s5_ovf_sticky", 32'(overflow), 32'd1);
        @(negedge clk);
        do_reset();
        #1;
        check("s5_ovf_cleared", 32'(overflow), 32'd0);
        @(negedge clk);

        // Scenario 6: reset while presenting byte 2, then recovery
        do_reset();
        tx_ready = 1'b1;
        write_word(25'h1ABCDEF);
        n = 0;
        while (got.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("s6_reached_byte2", 32'(got.size()), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("s6_valid", 32'(tx_valid), 32'd0);
        check("s6_count", 32'(count), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_rden", 32'(fifo_rden), 32'd0);
        @(negedge clk);
        clear_mon();
        push_exp(25'h1ABCDEF);
        write_word(25'h1ABCDEF);
        wait_idle("s6_after", 50);
        compare_stream("s6_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
